// File: rtl/prbs7_checker.sv
// PRBS7 (x^7 + x^6 + 1) serial stream checker.
// Hunts for lock by self-synchronising on the incoming data, then compares the
// input against a free-running reference and drops lock when too many bit errors
// land within one window of valid bits.
// Optional feature: define PRBS7_CHECKER_ERRCNT_EN to build the saturating
// 16-bit error counter and its CLR input. Without the macro, ERR_CNT is tied to 0
// and CLR is ignored.
module prbs7_checker #(
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_ERR = 4,
    parameter int unsigned WINDOW     = 64
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        D,
    input  logic        DV,
    input  logic        CLR,
    output logic        LOCK,
    output logic        ERR,
    output logic [15:0] ERR_CNT
);

    localparam logic [7:0]  LockCntV   = 8'(LOCK_CNT);
    localparam logic [15:0] UnlockErrV = 16'(UNLOCK_ERR);
    localparam logic [15:0] WinLastV   = 16'(WINDOW - 1);

    typedef enum logic [0:0] {StHunt, StLocked} state_e;

    state_e      state_q, state_d;
    logic [6:0]  s_q, s_d;        // bit history, newest in s_q[0]
    logic [2:0]  fill_q, fill_d;  // reaches 7 once the history is loaded
    logic [7:0]  match_q, match_d;
    logic [15:0] win_q, win_d;    // position inside the current window
    logic [15:0] werr_q, werr_d;  // errors seen in the current window
    logic        err_q, err_d;
    logic        cnt_inc;

    logic        pred;
    logic        mism;
    logic [7:0]  match_inc;
    logic [15:0] werr_inc;
    logic        win_last;

    assign pred      = s_q[6] ^ s_q[5];
    assign mism      = D ^ pred;
    assign match_inc = match_q + 8'd1;
    assign werr_inc  = werr_q + 16'(mism);
    assign win_last  = (win_q == WinLastV);

    // Next-state logic for the hunt/locked FSM and all per-bit counters.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        fill_d  = fill_q;
        match_d = match_q;
        win_d   = win_q;
        werr_d  = werr_q;
        err_d   = 1'b0;
        cnt_inc = 1'b0;
        if (DV) begin
            unique case (state_q)
                StHunt: begin
                    // Self-synchronising: the received bit always enters the history.
                    s_d = {s_q[5:0], D};
                    if (fill_q != 3'd7) begin
                        fill_d = fill_q + 3'd1;
                    end else if (!mism && (s_q != 7'd0)) begin
                        match_d = match_inc;
                        if (match_inc == LockCntV) begin
                            state_d = StLocked;
                            win_d   = 16'd0;
                            werr_d  = 16'd0;
                        end
                    end else begin
                        match_d = 8'd0;
                    end
                end
                StLocked: begin
                    // Free-running reference: the prediction, not the data, is kept.
                    s_d     = {s_q[5:0], pred};
                    err_d   = mism;
                    cnt_inc = mism;
                    // Error limit is tested before the window wrap so the last bit
                    // of a window still counts toward that window.
                    if (werr_inc == UnlockErrV) begin
                        state_d = StHunt;
                        fill_d  = 3'd0;
                        match_d = 8'd0;
                        win_d   = 16'd0;
                        werr_d  = 16'd0;
                    end else if (win_last) begin
                        win_d  = 16'd0;
                        werr_d = 16'd0;
                    end else begin
                        win_d  = win_q + 16'd1;
                        werr_d = werr_inc;
                    end
                end
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= StHunt;
            s_q     <= 7'd0;
            fill_q  <= 3'd0;
            match_q <= 8'd0;
            win_q   <= 16'd0;
            werr_q  <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            err_q   <= err_d;
        end
    end

    assign LOCK = (state_q == StLocked);
    assign ERR  = err_q;

`ifdef PRBS7_CHECKER_ERRCNT_EN
    logic [15:0] err_cnt_q;

    // Saturating error counter; CLR wins over a same-cycle increment.
    always_ff @(posedge CK) begin
        if (RST) begin
            err_cnt_q <= 16'd0;
        end else if (CLR) begin
            err_cnt_q <= 16'd0;
        end else if (cnt_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign ERR_CNT = err_cnt_q;
`else
    logic unused_cnt;

    assign unused_cnt = CLR ^ cnt_inc;
    assign ERR_CNT    = 16'd0;
`endif

endmodule

// File: tb/tb_prbs7_checker.sv
// Self-checking bench for prbs7_checker: directed scenarios plus a randomized
// phase, all compared against a queue-based reference model of the checker.
module tb_prbs7_checker;

    localparam int unsigned LOCK_CNT   = 16;
    localparam int unsigned UNLOCK_ERR = 4;
    localparam int unsigned WINDOW     = 64;

`ifdef PRBS7_CHECKER_ERRCNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        D = 1'b0;
    logic        DV = 1'b0;
    logic        CLR = 1'b0;
    logic        LOCK;
    logic        ERR;
    logic [15:0] ERR_CNT;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CK = ~CK;

    prbs7_checker #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_ERR (UNLOCK_ERR),
        .WINDOW     (WINDOW)
    ) dut (
        .CK      (CK),
        .RST     (RST),
        .D       (D),
        .DV      (DV),
        .CLR     (CLR),
        .LOCK    (LOCK),
        .ERR     (ERR),
        .ERR_CNT (ERR_CNT)
    );

    // Clean PRBS7 source: b[n] = b[n-7] ^ b[n-6], seeded with seven ones.
    bit gen_q[$];

    function automatic void gen_reset();
        gen_q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    endfunction

    function automatic bit gen_next();
        bit b;
        b = gen_q[0] ^ gen_q[1];
        gen_q.push_back(b);
        void'(gen_q.pop_front());
        return b;
    endfunction

    // Reference model: last seven bits as a queue, oldest first.
    bit m_hist[$];
    bit m_locked;
    bit m_err;
    int m_fill, m_match, m_wpos, m_werr, m_errcnt;

    function automatic void model_reset();
        m_hist   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_fill   = 0;
        m_match  = 0;
        m_wpos   = 0;
        m_werr   = 0;
        m_errcnt = 0;
    endfunction

    function automatic void model_push(bit b);
        m_hist.push_back(b);
        void'(m_hist.pop_front());
    endfunction

    function automatic void model_step(bit d, bit dv, bit clr);
        bit pred;
        bit zero;
        bit bad;
        bad   = 1'b0;
        m_err = 1'b0;
        if (dv) begin
            pred = m_hist[0] ^ m_hist[1];
            zero = (m_hist.sum() with (int'(item)) == 0);
            if (!m_locked) begin
                if (m_fill < 7) begin
                    m_fill++;
                end else if (d == pred && !zero) begin
                    m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_locked = 1'b1;
                        m_wpos   = 0;
                        m_werr   = 0;
                    end
                end else begin
                    m_match = 0;
                end
                model_push(d);
            end else begin
                bad = (d != pred);
                model_push(pred);
                if (bad) begin
                    m_err = 1'b1;
                    m_werr++;
                end
                if (m_werr == UNLOCK_ERR) begin
                    m_locked = 1'b0;
                    m_fill   = 0;
                    m_match  = 0;
                end else if (m_wpos == WINDOW - 1) begin
                    m_wpos = 0;
                    m_werr = 0;
                end else begin
                    m_wpos++;
                end
            end
        end
        if (CNT_EN != 0) begin
            if (clr) m_errcnt = 0;
            else if (bad && m_errcnt < 65535) m_errcnt++;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare outputs #1 after the edge.
    task automatic cycle(input bit d, input bit dv, input bit clr, input bit rst);
        D   = d;
        DV  = dv;
        CLR = clr;
        RST = rst;
        @(posedge CK);
        if (rst) model_reset();
        else model_step(d, dv, clr);
        #1;
        check("lock", 32'(LOCK), 32'(m_locked));
        check("err", 32'(ERR), 32'(m_err));
        check("err_cnt", 32'(ERR_CNT), 32'(m_errcnt));
    endtask

    task automatic send_clean();
        cycle(gen_next(), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_err();
        cycle(~gen_next(), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'($urandom), 1'b1, 1'b1, 1'b1);
        RST = 1'b0;
    endtask

    // Advance with clean bits until the model window position hits target.
    task automatic seek_wpos(input int target);
        int  n;
        bit  found;
        found = 1'b0;
        n     = 0;
        while (!found && n < 4 * WINDOW) begin
            if (m_locked && m_wpos == target) found = 1'b1;
            else send_clean();
            n++;
        end
        check("seek_wpos", 32'(found), 32'd1);
    endtask

    initial begin
        int  v;
        bit  saw_lock;
        bit  dv;
        gen_reset();
        model_reset();

        // Reset state.
        do_reset();
        check("rst_lock", 32'(LOCK), 32'd0);
        check("rst_errcnt", 32'(ERR_CNT), 32'd0);

        // Clean stream: lock after valid bit 23, no errors through 1000 bits.
        for (int i = 1; i <= 22; i++) send_clean();
        check("lock_b22", 32'(LOCK), 32'd0);
        send_clean();
        check("lock_b23", 32'(LOCK), 32'd1);
        for (int i = 24; i <= 1000; i++) send_clean();
        check("clean_lock", 32'(LOCK), 32'd1);
        check("clean_errcnt", 32'(ERR_CNT), 32'd0);

        // Single inverted bit while locked.
        send_err();
        check("single_err", 32'(ERR), 32'd1);
        send_clean();
        check("single_err_gone", 32'(ERR), 32'd0);
        check("single_lock", 32'(LOCK), 32'd1);
        check("single_cnt", 32'(ERR_CNT), 32'(CNT_EN));

        // Four errors inside one window: unlock, then relock after 23 bits.
        seek_wpos(0);
        for (int k = 0; k < 20; k++) begin
            if (k % 5 == 4) send_err();
            else send_clean();
        end
        check("burst_unlock", 32'(LOCK), 32'd0);
        check("burst_err", 32'(ERR), 32'd1);
        check("burst_cnt", 32'(ERR_CNT), 32'(5 * CNT_EN));
        for (int i = 1; i <= 22; i++) send_clean();
        check("relock_b22", 32'(LOCK), 32'd0);
        send_clean();
        check("relock_b23", 32'(LOCK), 32'd1);

        // Two errors at the end of a window and two at the start of the next.
        seek_wpos(WINDOW - 2);
        for (int k = 0; k < 4; k++) send_err();
        send_clean();
        check("split_lock", 32'(LOCK), 32'd1);
        check("split_cnt", 32'(ERR_CNT), 32'(9 * CNT_EN));

        // CLR together with an error.
        cycle(~gen_next(), 1'b1, 1'b1, 1'b0);
        check("clr_err", 32'(ERR), 32'd1);
        check("clr_cnt", 32'(ERR_CNT), 32'd0);

        // DV toggling: lock point still counted in valid bits.
        gen_reset();
        do_reset();
        v  = 0;
        dv = 1'b1;
        while (v < 23) begin
            if (dv) begin
                send_clean();
                v++;
                if (v == 22) check("dv_lock_b22", 32'(LOCK), 32'd0);
                if (v == 23) check("dv_lock_b23", 32'(LOCK), 32'd1);
            end else begin
                cycle(1'($urandom), 1'b0, 1'b0, 1'b0);
                check("dv_idle_err", 32'(ERR), 32'd0);
            end
            dv = ~dv;
        end

        // Mid-stream reset discards lock; reacquire in 7 + LOCK_CNT bits.
        for (int i = 0; i < 40; i++) send_clean();
        do_reset();
        check("midrst_lock", 32'(LOCK), 32'd0);
        for (int i = 1; i <= 22; i++) send_clean();
        check("midrst_b22", 32'(LOCK), 32'd0);
        send_clean();
        check("midrst_b23", 32'(LOCK), 32'd1);

        // Randomized traffic: gaps, sparse errors, occasional CLR and reset.
        for (int i = 0; i < 4000; i++) begin
            dv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1999) == 0) begin
                do_reset();
            end else if (!dv) begin
                cycle(1'($urandom), 1'b0, ($urandom_range(0, 49) == 0), 1'b0);
            end else begin
                cycle(gen_next() ^ ($urandom_range(0, 39) == 0), 1'b1,
                      ($urandom_range(0, 49) == 0), 1'b0);
            end
        end

        // All-zero input must never lock.
        do_reset();
        saw_lock = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            saw_lock |= LOCK;
        end
        check("zeros_nolock", 32'(saw_lock), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
